// File: rtl/nic_pkg.sv
// Shared constants and types for the cardinal NIC: widths, register map and
// the channel-buffer state encoding.
package nic_pkg;

  localparam int DATA_W = 64;
  localparam int VC_BIT = 63;

  localparam logic [1:0] ADDR_IN_BUF   = 2'd0;
  localparam logic [1:0] ADDR_IN_STAT  = 2'd1;
  localparam logic [1:0] ADDR_OUT_BUF  = 2'd2;
  localparam logic [1:0] ADDR_OUT_STAT = 2'd3;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } chan_state_t;

  // Zero-extend a one-bit status flag to a full register word.
  function automatic logic [DATA_W-1:0] status_word(input logic flag);
    return {{(DATA_W-1){1'b0}}, flag};
  endfunction

endpackage

// File: rtl/nic_chan_buf.sv
// Single-entry channel buffer: EMPTY accepts a load, FULL waits for a clear.
// The data register keeps its last contents after a clear.
module nic_chan_buf
  import nic_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              clear,
  output logic              full,
  output logic [DATA_W-1:0] data
);

  chan_state_t       state_q;
  logic [DATA_W-1:0] data_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      data_q  <= '0;
    end else begin
      case (state_q)
        EMPTY: if (load) begin
          data_q  <= load_data;
          state_q <= FULL;
        end
        FULL: if (clear) begin
          state_q <= EMPTY;
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign full = (state_q == FULL);
  assign data = data_q;

endmodule

// File: rtl/cardinal_nic.sv
// Processor-to-router network interface: register decode, injection gating
// and read mux around two single-entry channel buffers.
// Optional: define NIC_POLARITY_GATE_EN to offer a packet only in the router
// phase where its VC bit selects the external link.
module cardinal_nic
  import nic_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out,
  input  logic              nicEn,
  input  logic              nicWrEn,
  output logic              net_si,
  output logic [DATA_W-1:0] net_di,
  input  logic              net_ri,
  input  logic              net_so,
  input  logic [DATA_W-1:0] net_do,
  output logic              net_ro,
  input  logic              net_polarity
);

  logic              wr_en;
  logic              rd_en;
  logic              out_full;
  logic [DATA_W-1:0] out_data;
  logic              in_full;
  logic [DATA_W-1:0] in_data;
  logic              gate;
  logic              out_load;
  logic              out_clear;
  logic              in_load;
  logic              in_clear;
  logic [DATA_W-1:0] d_out_q;
  logic [DATA_W-1:0] d_out_d;

  assign wr_en = nicEn & nicWrEn;
  assign rd_en = nicEn & ~nicWrEn;

`ifdef NIC_POLARITY_GATE_EN
  assign gate = (out_data[VC_BIT] != net_polarity);
`else
  logic unused_polarity;
  assign unused_polarity = net_polarity;
  assign gate            = 1'b1;
`endif

  // Writes to a full buffer are dropped inside the buffer, which ignores load.
  assign out_load  = wr_en & (addr == ADDR_OUT_BUF);
  assign out_clear = net_si & net_ri;
  assign in_load   = net_so & net_ro;
  assign in_clear  = rd_en & (addr == ADDR_IN_BUF);

  nic_chan_buf u_out_buf (
    .clk       (clk),
    .reset     (reset),
    .load      (out_load),
    .load_data (d_in),
    .clear     (out_clear),
    .full      (out_full),
    .data      (out_data)
  );

  nic_chan_buf u_in_buf (
    .clk       (clk),
    .reset     (reset),
    .load      (in_load),
    .load_data (net_do),
    .clear     (in_clear),
    .full      (in_full),
    .data      (in_data)
  );

  // NOTE: every path assigns d_out_d, starting from a hold default, so no
  // latch is inferred.
  always_comb begin
    d_out_d = d_out_q;
    if (rd_en) begin
      case (addr)
        ADDR_IN_BUF:   d_out_d = in_data;
        ADDR_IN_STAT:  d_out_d = status_word(in_full);
        ADDR_OUT_BUF:  d_out_d = '0;
        ADDR_OUT_STAT: d_out_d = status_word(out_full);
        default:       d_out_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) d_out_q <= '0;
    else       d_out_q <= d_out_d;
  end

  assign d_out  = d_out_q;
  assign net_si = out_full & gate;
  assign net_di = out_data;
  assign net_ro = ~in_full;

endmodule

// File: doc/cardinal_nic.md
Name: cardinal_nic

Overview:
- Network interface controller between one processor (PE) and one router tile's PE port.
- Processor side: 2-bit addressed register interface exposing one output (injection) channel buffer, one input (ejection) channel buffer and their status words.
- Router side: drives the router's pe_si/pe_di, consumes pe_ri; receives pe_so/pe_do, drives pe_ro. Uses the router's polarity output to gate injection by virtual channel.
- One instance per mesh node.

Parameters:
- DATA_W, 64, packet/register width.
- VC_BIT, 63, bit position of the virtual-channel bit inside a packet.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- addr  in  2  register select: 0 = input buf, 1 = input status, 2 = output buf, 3 = output status
- d_in  in  DATA_W  processor write data
- d_out  out  DATA_W  processor read data (registered)
- nicEn  in  1  access enable
- nicWrEn  in  1  1 = write, 0 = read (qualified by nicEn)
- net_si  out  1  NIC→router valid (to router pe_si)
- net_di  out  DATA_W  NIC→router packet (to router pe_di)
- net_ri  in  1  router ready for NIC (from router pe_ri)
- net_so  in  1  router→NIC valid (from router pe_so)
- net_do  in  DATA_W  router→NIC packet (from router pe_do)
- net_ro  out  1  NIC ready for router (to router pe_ro)
- net_polarity  in  1  router phase (from router polarity)

Behaviour:
- Reset (sync, active-high): in_full=0, out_full=0, both buffers=0, d_out=0. Outputs net_si=0, net_di=0, net_ro=1. Reset mid-transfer discards both buffers; no partial state survives.
- Each channel is a 2-state FSM: EMPTY ↔ FULL, with a single-entry DATA_W register.
- Output channel:
  - Processor write (nicEn=1, nicWrEn=1, addr=2): accepted only if out_full=0. Captures d_in and sets out_full next edge.
  - A write while full is dropped; buffer is unchanged.
  - net_di = out buffer. net_si = out_full & gate (combinational from registers and net_polarity).
  - Transfer occurs when net_si & net_ri; out_full clears on the next edge.
  - A write and a drain cannot coincide, because writes require out_full=0.
- Input channel:
  - net_ro = ~in_full (registered state).
  - When net_so & net_ro: capture net_do and set in_full next edge.
  - Processor read of addr 0 when in_full=1: d_out ← in buffer next edge, and in_full clears on the same edge.
  - Read of addr 0 when empty: d_out ← in buffer contents (stale), no state change.
  - Arrival and drain cannot coincide, because arrival requires in_full=0.
- Status reads:
  - addr 1 → d_out = {DATA_W-1 zeros, in_full}.
  - addr 3 → d_out = {DATA_W-1 zeros, out_full}.
- Read rules:
  - Read latency is 1 cycle.
  - d_out holds its last value when there is no read.
  - Reads of addr 2 return 0.
  - Writes to addr 0/1/3 are ignored.
  - nicEn=0 means no access.
- Widths: status zero-extended; no arithmetic.

Optional Feature:
- Macro: NIC_POLARITY_GATE_EN.
- Defined: gate = (out_buf[VC_BIT] != net_polarity), so a packet is offered only in the phase where its VC uses the external link. A packet waits in FULL, with net_si=0, during the wrong phase.
- Undefined: gate = 1; net_si = out_full regardless of polarity.

Decomposition:
- Package nic_pkg: DATA_W, VC_BIT, address constants ADDR_IN_BUF=0, ADDR_IN_STAT=1, ADDR_OUT_BUF=2, ADDR_OUT_STAT=3, FSM encodings EMPTY/FULL.
- Sub-module nic_chan_buf: single-entry buffer with full flag, load/clear handshake. Instantiated twice, once for input and once for output; cardinal_nic adds decode, gating and d_out mux.

Test Plan:
- Reset then idle: d_out=0, net_si=0, net_ro=1; read addr 3 → d_out=0 next cycle.
- Write addr 2 = 64'h0000_0000_0000_00A5 with net_ri=1 (gate undefined): net_si=1 with net_di=…A5 one cycle later. Next cycle net_si=0, and a status read returns 0.
- Backpressure: net_ri=0 with out_full; a second write of 64'h…BB is dropped. Release net_ri → the delivered packet is …A5.
- Ejection: net_so=1, net_do=64'h8000_0000_0000_1234 → net_ro=0 next cycle. A second net_so packet is held off. Read addr 1 → 1; read addr 0 → d_out=…1234; then net_ro=1.
- NIC_POLARITY_GATE_EN: out packet with bit63=1. net_si=1 only in cycles where net_polarity=0; with net_ri=1 throughout, it is sent in the first such cycle.
- Reset asserted while out_full=1 and in_full=1: next cycle net_si=0, net_ro=1, both status reads return 0.
